// File: rtl/ft245_tx_arbiter.sv
// ft245_tx_arbiter
// Round-robin arbiter that shares one FT245 transmit byte stream among
// NUM_SRC sources. Each grant emits a header byte {HDR_TAG, source index}
// followed by up to MAX_BURST payload bytes of the granted source's frame.
// The payload path is a combinational pass-through so a source sees the
// FT245 ack in the same cycle it presents a byte.

module ft245_tx_arbiter #(
    parameter int          NUM_SRC    = 4,
    parameter int          DATA_WIDTH = 8,
    parameter int          MAX_BURST  = 16,
    parameter logic [3:0]  HDR_TAG    = 4'hA
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_rdy,
    input  logic [NUM_SRC-1:0]            src_last,
    output logic [NUM_SRC-1:0]            src_ack,
    output logic [DATA_WIDTH-1:0]         tx_data_si,
    output logic                          tx_rdy_si,
    input  logic                          tx_ack_si,
    output logic [3:0]                    grant,
    output logic                          busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_e;

    // Counter value of the last byte a single grant may carry.
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_e          state_q, state_d;
    logic [3:0]      grant_q, grant_d;
    logic [3:0]      last_q,  last_d;
    logic [7:0]      cnt_q,   cnt_d;

    logic [DATA_WIDTH-1:0] sel_data_s;
    logic                  sel_rdy_s;
    logic                  sel_last_s;
    logic                  pick_found_s;
    logic [3:0]            pick_idx_s;
    logic                  xfer_s;
    logic [DATA_WIDTH-1:0] hdr_s;

    // Header byte is built only from registered grant, so it is glitch-free.
    assign hdr_s = DATA_WIDTH'({HDR_TAG, grant_q});

    // Multiplex the granted source's byte, ready and last flag.
    always_comb begin
        sel_data_s = '0;
        sel_rdy_s  = 1'b0;
        sel_last_s = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (grant_q == 4'(j)) begin
                sel_data_s = src_data[j*DATA_WIDTH +: DATA_WIDTH];
                sel_rdy_s  = src_rdy[j];
                sel_last_s = src_last[j];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Round-robin pick: first requesting source after the last grant.
    always_comb begin
        int idx_v;
        idx_v        = 0;
        pick_found_s = 1'b0;
        pick_idx_s   = 4'd0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx_v = int'(last_q) + k;
            if (idx_v >= NUM_SRC) begin
                idx_v = idx_v - NUM_SRC;
            end else begin
                idx_v = idx_v;
            end
            for (int j = 0; j < NUM_SRC; j++) begin
                if (!pick_found_s && (j == idx_v) && src_rdy[j]) begin
                    pick_found_s = 1'b1;
                    pick_idx_s   = 4'(j);
                end else begin
                    pick_found_s = pick_found_s;
                end
            end
        end
    end

    // A payload byte moves only while in DATA with both handshakes high.
    assign xfer_s = (state_q == ST_DATA) && sel_rdy_s && tx_ack_si;

    // Next-state logic for the grant / header / payload sequence.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    grant_d = pick_idx_s;
                    cnt_d   = 8'd0;
                    state_d = ST_HEADER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (tx_ack_si) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_HEADER;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    cnt_d = cnt_q + 8'd1;
                    if (sel_last_s || (cnt_q == BURST_LAST)) begin
                        state_d = ST_IDLE;
                        last_d  = grant_q;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant, round-robin pointer and burst counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= 4'd0;
            last_q  <= 4'(NUM_SRC - 1);
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode: header from registers, payload passed straight through.
    always_comb begin
        tx_data_si = '0;
        tx_rdy_si  = 1'b0;
        src_ack    = '0;
        case (state_q)
            ST_IDLE: begin
                tx_data_si = '0;
                tx_rdy_si  = 1'b0;
            end
            ST_HEADER: begin
                tx_data_si = hdr_s;
                tx_rdy_si  = 1'b1;
            end
            ST_DATA: begin
                tx_data_si = sel_data_s;
                tx_rdy_si  = sel_rdy_s;
                for (int j = 0; j < NUM_SRC; j++) begin
                    if (grant_q == 4'(j)) begin
                        src_ack[j] = tx_ack_si & sel_rdy_s;
                    end else begin
                        src_ack[j] = 1'b0;
                    end
                end
            end
            default: begin
                tx_data_si = '0;
                tx_rdy_si  = 1'b0;
            end
        endcase
    end

    assign grant = grant_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// Directed testbench for ft245_tx_arbiter (NUM_SRC=4, MAX_BURST=16).
// Sources are modelled as per-source byte FIFOs that pop on src_ack;
// bytes accepted by the FT245 side are captured and compared against
// hand-computed sequences.

module tb_ft245_tx_arbiter;

    localparam int NS = 4;

    logic             clk;
    logic             rst;
    logic [NS*8-1:0]  src_data;
    logic [NS-1:0]    src_rdy;
    logic [NS-1:0]    src_last;
    logic [NS-1:0]    src_ack;
    logic [7:0]       tx_data_si;
    logic             tx_rdy_si;
    logic             tx_ack_si;
    logic [3:0]       grant;
    logic             busy;

    ft245_tx_arbiter #(
        .NUM_SRC(NS), .DATA_WIDTH(8), .MAX_BURST(16), .HDR_TAG(4'hA)
    ) dut (
        .clk(clk), .rst(rst),
        .src_data(src_data), .src_rdy(src_rdy), .src_last(src_last),
        .src_ack(src_ack),
        .tx_data_si(tx_data_si), .tx_rdy_si(tx_rdy_si), .tx_ack_si(tx_ack_si),
        .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source FIFOs
    logic [7:0] smem  [NS][64];
    logic       slast [NS][64];
    int         srd   [NS];
    int         swr   [NS];
    logic       sen   [NS];
    int         ack_cnt [NS];

    // Captured FT245 bytes
    logic [7:0] cap [256];
    int         cap_n;

    int n_cmp;
    int n_err;

    logic [7:0] exp2 [15] = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h11, 8'h12,
                              8'hA2, 8'h21, 8'h22, 8'hA3, 8'h31, 8'h32,
                              8'hA0, 8'h05, 8'h06};
    logic [7:0] exp3 [43];
    logic [7:0] exp5 [8]  = '{8'hA1, 8'h61, 8'h62, 8'h63, 8'h64,
                              8'hA3, 8'h71, 8'h72};
    logic [7:0] exp6 [5]  = '{8'hA0, 8'h81, 8'h82, 8'hA1, 8'h91};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int s, input logic [7:0] b, input logic l);
        smem[s][swr[s]]  = b;
        slast[s][swr[s]] = l;
        swr[s]++;
    endtask

    task automatic drive_srcs();
        for (int s = 0; s < NS; s++) begin
            if (sen[s] && (srd[s] < swr[s])) begin
                src_rdy[s]         = 1'b1;
                src_data[s*8 +: 8] = smem[s][srd[s]];
                src_last[s]        = slast[s][srd[s]];
            end else begin
                src_rdy[s]         = 1'b0;
                src_data[s*8 +: 8] = 8'h00;
                src_last[s]        = 1'b0;
            end
        end
    endtask

    // Called at a negedge: drive, sample just before the posedge, return at next negedge.
    task automatic tick();
        drive_srcs();
        #4;
        if (tx_rdy_si && tx_ack_si) begin
            cap[cap_n] = tx_data_si;
            cap_n++;
        end
        for (int s = 0; s < NS; s++) begin
            if (src_ack[s]) begin
                ack_cnt[s]++;
                srd[s]++;
            end
        end
        @(negedge clk);
        drive_srcs();
    endtask

    task automatic clear_bench();
        for (int s = 0; s < NS; s++) begin
            srd[s] = 0; swr[s] = 0; sen[s] = 1'b0; ack_cnt[s] = 0;
        end
        cap_n = 0;
        drive_srcs();
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        tx_ack_si = 1'b0;
        clear_bench();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_until(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (((cap_n < n) || busy) && (k < budget)) begin
            tick();
            k++;
        end
        check(tag, (k < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        tx_ack_si = 1'b0;
        src_data = '0; src_rdy = '0; src_last = '0;
        clear_bench();

        // Reset state
        #3;
        check("rst_tx_rdy",  32'(tx_rdy_si), 32'd0);
        check("rst_tx_data", 32'(tx_data_si), 32'd0);
        check("rst_src_ack", 32'(src_ack), 32'd0);
        check("rst_grant",   32'(grant), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // 1: single 3-byte frame from source 0
        push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
        sen[0] = 1'b1;
        tx_ack_si = 1'b1;
        run_until("t1_timeout", 4, 20);
        check("t1_cnt", 32'(cap_n), 32'd4);
        check("t1_b0", 32'(cap[0]), 32'hA0);
        check("t1_b1", 32'(cap[1]), 32'h11);
        check("t1_b2", 32'(cap[2]), 32'h22);
        check("t1_b3", 32'(cap[3]), 32'h33);
        check("t1_acks", 32'(ack_cnt[0]), 32'd3);
        check("t1_busy", 32'(busy), 32'd0);

        // 2: all sources requesting, 2-byte frames, round-robin order
        do_reset();
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1);
        push(0, 8'h05, 1'b0); push(0, 8'h06, 1'b1);
        push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
        push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b1);
        for (int s = 0; s < NS; s++) sen[s] = 1'b1;
        tx_ack_si = 1'b1;
        run_until("t2_timeout", 15, 80);
        check("t2_cnt", 32'(cap_n), 32'd15);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("t2_b%0d", i), 32'(cap[i]), 32'(exp2[i]));
        end

        // 3: 40-byte frame from source 2 split by the 16-byte burst limit
        do_reset();
        for (int i = 0; i < 40; i++) push(2, 8'(8'h40 + i), (i == 39) ? 1'b1 : 1'b0);
        for (int i = 0; i < 43; i++) begin
            if (i == 0 || i == 17 || i == 34) exp3[i] = 8'hA2;
            else if (i < 17)                  exp3[i] = 8'(8'h40 + i - 1);
            else if (i < 34)                  exp3[i] = 8'(8'h40 + i - 2);
            else                              exp3[i] = 8'(8'h40 + i - 3);
        end
        sen[2] = 1'b1;
        tx_ack_si = 1'b1;
        run_until("t3_timeout", 43, 120);
        check("t3_cnt", 32'(cap_n), 32'd43);
        for (int i = 0; i < 43; i++) begin
            check($sformatf("t3_b%0d", i), 32'(cap[i]), 32'(exp3[i]));
        end

        // 4: FT245 back-pressure in HEADER and in DATA
        do_reset();
        push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b0); push(1, 8'h53, 1'b1);
        sen[1] = 1'b1;
        tx_ack_si = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t4_hdr_data", 32'(tx_data_si), 32'hA1);
            check("t4_hdr_rdy",  32'(tx_rdy_si), 32'd1);
            check("t4_hdr_ack",  32'(src_ack), 32'd0);
            tick();
        end
        tx_ack_si = 1'b1;
        tick();
        tick();
        tx_ack_si = 1'b0;
        drive_srcs();
        #1;
        for (int i = 0; i < 5; i++) begin
            check("t4_dat_data", 32'(tx_data_si), 32'h52);
            check("t4_dat_ack",  32'(src_ack), 32'd0);
            tick();
        end
        tx_ack_si = 1'b1;
        run_until("t4_timeout", 4, 20);
        check("t4_cnt", 32'(cap_n), 32'd4);
        check("t4_b0", 32'(cap[0]), 32'hA1);
        check("t4_b1", 32'(cap[1]), 32'h51);
        check("t4_b2", 32'(cap[2]), 32'h52);
        check("t4_b3", 32'(cap[3]), 32'h53);
        check("t4_acks", 32'(ack_cnt[1]), 32'd3);

        // 5: granted source stalls while another requests
        do_reset();
        push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b0);
        push(1, 8'h63, 1'b0); push(1, 8'h64, 1'b1);
        push(3, 8'h71, 1'b0); push(3, 8'h72, 1'b1);
        sen[1] = 1'b1;
        tx_ack_si = 1'b1;
        tick();
        tick();
        tick();
        sen[1] = 1'b0;
        sen[3] = 1'b1;
        drive_srcs();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_grant",  32'(grant), 32'd1);
            check("t5_ack3",   32'(src_ack[3]), 32'd0);
            check("t5_tx_rdy", 32'(tx_rdy_si), 32'd0);
            check("t5_busy",   32'(busy), 32'd1);
        end
        sen[1] = 1'b1;
        run_until("t5_timeout", 8, 40);
        check("t5_cnt", 32'(cap_n), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t5_b%0d", i), 32'(cap[i]), 32'(exp5[i]));
        end
        check("t5_acks3", 32'(ack_cnt[3]), 32'd2);

        // 6: asynchronous reset mid-DATA, then priority restarts at source 0
        do_reset();
        for (int i = 0; i < 8; i++) push(0, 8'(8'hC0 + i), (i == 7) ? 1'b1 : 1'b0);
        sen[0] = 1'b1;
        tx_ack_si = 1'b1;
        tick();
        tick();
        tick();
        check("t6_pre_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_tx_rdy",  32'(tx_rdy_si), 32'd0);
        check("t6_rst_src_ack", 32'(src_ack), 32'd0);
        check("t6_rst_busy",    32'(busy), 32'd0);
        check("t6_rst_grant",   32'(grant), 32'd0);
        clear_bench();
        push(0, 8'h81, 1'b0); push(0, 8'h82, 1'b1);
        push(1, 8'h91, 1'b1);
        sen[0] = 1'b1;
        sen[1] = 1'b1;
        drive_srcs();
        @(negedge clk);
        rst = 1'b1;
        run_until("t6_timeout", 5, 30);
        check("t6_cnt", 32'(cap_n), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t6_b%0d", i), 32'(cap[i]), 32'(exp6[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
